// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants and helpers for the mux_stream slice.
//                MODE_SEL / MODE_RR encode the 1-bit mode input; clog2
//                sizes the channel-select fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arb
//  Description : Combinational round-robin arbiter. Grants the first
//                requesting channel found searching upward from ptr+1,
//                wrapping CHANNELS-1 -> 0.
//  Ports       : req   - per-channel request vector
//                ptr   - last granted channel (search starts just above it)
//                grant - one-hot grant, all zero when nothing requests
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant
);

    int w_dist;
    int w_bestDist;

    // Each channel's distance from ptr+1 in search order; the nearest
    // requesting channel wins. ptr never exceeds CHANNELS-1, so the
    // dividend stays non-negative.
    always_comb begin
        grant      = '0;
        w_dist     = 0;
        w_bestDist = CHANNELS;
        for (int c = 0; c < CHANNELS; c++) begin
            w_dist = (c + CHANNELS - 1 - int'(ptr)) % CHANNELS;
            if (req[c] && (w_dist < w_bestDist)) begin
                w_bestDist = w_dist;
                grant      = '0;
                grant[c]   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream
//  Description : N-channel valid/ready stream multiplexer with a single
//                registered output stage (latency 1, full throughput).
//                Select mode forwards channel `sel`; round-robin mode
//                (built only when MUX_STREAM_RR_EN is defined) rotates
//                fairly over the valid channels.
//  Config      : `define MUX_STREAM_RR_EN to build round-robin arbitration
//                and honour `mode`; otherwise `mode` is ignored.
//  Ports       : clk, reset (async, active-high)
//                in_data/in_valid/in_ready - CHANNELS input streams,
//                  channel c at in_data[c*WIDTH +: WIDTH]
//                sel, mode                 - channel select / arbitration mode
//                out_data/out_chan/out_valid/out_ready - output stream
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    r_outData;
    logic [SEL_W-1:0]    r_outChan;
    logic                r_outValid;

    logic [CHANNELS-1:0] w_selGrant;
    logic [CHANNELS-1:0] w_grant;
    logic [SEL_W-1:0]    w_grantIdx;
    logic [WIDTH-1:0]    w_grantData;
    logic                w_canLoad;
    logic                w_inXfer;

    // Select-mode grant: comparing against every legal index means an
    // out-of-range sel simply matches nothing.
    always_comb begin
        w_selGrant = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == SEL_W'(c)) begin
                w_selGrant[c] = in_valid[c];
            end
        end
    end

`ifdef MUX_STREAM_RR_EN
    logic [SEL_W-1:0]    r_rrPtr;
    logic [CHANNELS-1:0] w_rrGrant;

    mux_rr_arb #(
        .CHANNELS (CHANNELS)
    ) u_rrArb (
        .req   (in_valid),
        .ptr   (r_rrPtr),
        .grant (w_rrGrant)
    );

    assign w_grant = (mode == MODE_RR) ? w_rrGrant : w_selGrant;

    // Reset to the last channel so channel 0 is searched first. The pointer
    // moves only on an accepted beat, so stalls keep the rotation position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr <= SEL_W'(CHANNELS - 1);
        end else if (w_inXfer) begin
            r_rrPtr <= w_grantIdx;
        end
    end
`else
    logic w_unusedMode;
    assign w_unusedMode = mode;
    assign w_grant      = w_selGrant;
`endif

    // Grant is one-hot (or empty): encode its index and pick its data.
    always_comb begin
        w_grantIdx  = '0;
        w_grantData = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_grant[c]) begin
                w_grantIdx  = SEL_W'(c);
                w_grantData = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can take a beat when empty or being drained this
    // cycle. Reset masks ready explicitly so nothing is offered while held.
    assign w_canLoad = ~r_outValid | out_ready;
    assign in_ready  = w_grant & {CHANNELS{w_canLoad & ~reset}};
    assign w_inXfer  = |in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outData  <= '0;
            r_outChan  <= '0;
            r_outValid <= 1'b0;
        end else if (w_inXfer) begin
            r_outData  <= w_grantData;
            r_outChan  <= w_grantIdx;
            r_outValid <= 1'b1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_data  = r_outData;
    assign out_chan  = r_outChan;
    assign out_valid = r_outValid;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_stream
//  Description : Directed self-checking bench for mux_stream. A 4-channel
//                instance covers select, backpressure, mode handling and
//                mid-operation reset; a 3-channel instance covers the
//                out-of-range select. Round-robin vectors apply when
//                MUX_STREAM_RR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_stream;

    logic        clk;
    logic        reset;

    logic [63:0] inData;
    logic [3:0]  inValid;
    logic [3:0]  inReady;
    logic [1:0]  sel;
    logic        mode;
    logic [15:0] outData;
    logic [1:0]  outChan;
    logic        outValid;
    logic        outReady;

    logic [47:0] inData3;
    logic [2:0]  inValid3;
    logic [2:0]  inReady3;
    logic [1:0]  sel3;
    logic [15:0] outData3;
    logic [1:0]  outChan3;
    logic        outValid3;
    logic        outReady3;

    int nChecks;
    int nErrors;

    mux_stream #(.WIDTH(16), .CHANNELS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .sel       (sel),
        .mode      (mode),
        .out_data  (outData),
        .out_chan  (outChan),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    mux_stream #(.WIDTH(16), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (inData3),
        .in_valid  (inValid3),
        .in_ready  (inReady3),
        .sel       (sel3),
        .mode      (1'b0),
        .out_data  (outData3),
        .out_chan  (outChan3),
        .out_valid (outValid3),
        .out_ready (outReady3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nChecks   = 0;
        nErrors   = 0;
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        inValid   = 4'b0000;
        inData    = '0;
        outReady  = 1'b0;
        sel3      = 2'd0;
        inValid3  = 3'b000;
        inData3   = '0;
        outReady3 = 1'b0;

        // Reset state; ready must stay low even with every channel valid.
        #2;
        inValid = 4'b1111;
        #1;
        check("rst_in_ready", 32'(inReady), 32'h0);
        check("rst_out_valid", 32'(outValid), 32'h0);
        check("rst_out_data", 32'(outData), 32'h0);
        check("rst_out_chan", 32'(outChan), 32'h0);
        check("rst_out_valid3", 32'(outValid3), 32'h0);
        tick();
        tick();

        // Select channel 2, first edge after reset release.
        reset    = 1'b0;
        mode     = 1'b0;
        sel      = 2'd2;
        inValid  = 4'b0100;
        inData   = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        outReady = 1'b1;
        #1;
        check("sel_in_ready", 32'(inReady), 32'h4);
        tick();
        check("sel_out_data", 32'(outData), 32'hBEEF);
        check("sel_out_chan", 32'(outChan), 32'h2);
        check("sel_out_valid", 32'(outValid), 32'h1);

        // Backpressure: hold 1234 while channel 1 waits.
        inData = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
        tick();
        check("bp_load", 32'(outData), 32'h1234);
        outReady = 1'b0;
        sel      = 2'd1;
        inValid  = 4'b0010;
        inData   = {16'h0000, 16'h1234, 16'h5678, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready", 32'(inReady), 32'h0);
            check("bp_hold_data", 32'(outData), 32'h1234);
            check("bp_hold_chan", 32'(outChan), 32'h2);
            check("bp_hold_valid", 32'(outValid), 32'h1);
            tick();
        end
        outReady = 1'b1;
        #1;
        check("bp_release_ready", 32'(inReady), 32'h2);
        tick();
        check("bp_new_data", 32'(outData), 32'h5678);
        check("bp_new_chan", 32'(outChan), 32'h1);

        // Drain with no new input clears out_valid.
        inValid = 4'b0000;
        #1;
        check("idle_in_ready", 32'(inReady), 32'h0);
        tick();
        check("drain_valid", 32'(outValid), 32'h0);

        inData = {16'hCC33, 16'h2222, 16'h1111, 16'h0F0F};

`ifdef MUX_STREAM_RR_EN
        // Round-robin from a fresh reset: 0,1,2,3,0.
        reset = 1'b1;
        #1;
        reset   = 1'b0;
        mode    = 1'b1;
        sel     = 2'd2;
        inValid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_seq_chan", 32'(outChan), 32'(k % 4));
        end
        check("rr_seq_data", 32'(outData), 32'h0F0F);
        // Skip: only 0 and 3 valid after a ch0 grant -> 3 then 0.
        inValid = 4'b1001;
        tick();
        check("rr_skip_chan3", 32'(outChan), 32'h3);
        check("rr_skip_data3", 32'(outData), 32'hCC33);
        tick();
        check("rr_skip_chan0", 32'(outChan), 32'h0);
`else
        // Without round-robin support, mode is ignored.
        mode    = 1'b1;
        sel     = 2'd1;
        inValid = 4'b1111;
        #1;
        check("mode_ignored_ready", 32'(inReady), 32'h2);
        tick();
        check("mode_ignored_chan", 32'(outChan), 32'h1);
        check("mode_ignored_data", 32'(outData), 32'h1111);
        tick();
        check("mode_ignored_chan2", 32'(outChan), 32'h1);
`endif

        // Reset between edges with a beat held.
        check("pre_rst_valid", 32'(outValid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(outValid), 32'h0);
        check("midrst_data", 32'(outData), 32'h0);
        check("midrst_chan", 32'(outChan), 32'h0);
        tick();
        check("midrst_in_ready", 32'(inReady), 32'h0);
        reset   = 1'b0;
        sel     = 2'd0;
        inValid = 4'b1111;
        #1;
        check("postrst_in_ready", 32'(inReady), 32'h1);
        tick();
        check("postrst_chan", 32'(outChan), 32'h0);
        check("postrst_valid", 32'(outValid), 32'h1);

        // Three-channel instance: sel=3 is out of range.
        sel3      = 2'd3;
        inValid3  = 3'b111;
        inData3   = {16'hA5A5, 16'h0002, 16'h0001};
        outReady3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("oor_in_ready", 32'(inReady3), 32'h0);
            tick();
            check("oor_out_valid", 32'(outValid3), 32'h0);
        end
        sel3 = 2'd2;
        #1;
        check("ch3_in_ready", 32'(inReady3), 32'h4);
        tick();
        check("ch3_out_chan", 32'(outChan3), 32'h2);
        check("ch3_out_data", 32'(outData3), 32'hA5A5);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_stream.md
MUX_STREAM -- requirements
Module: mux_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per channel (Hack word).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels, legal range 2..16.
REQ-003 SHALL derive localparam SEL_W = clog2(CHANNELS); it SHALL NOT be overridable.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel beat offered.
REQ-008 SHALL have port in_ready  output  CHANNELS  per-channel beat accepted.
REQ-009 SHALL have port sel  input  SEL_W  channel select in select mode.
REQ-010 SHALL have port mode  input  1  0 = select mode, 1 = round-robin (only with MUX_STREAM_RR_EN).
REQ-011 SHALL have port out_data  output  WIDTH  registered selected beat.
REQ-012 SHALL have port out_chan  output  SEL_W  source channel of out_data.
REQ-013 SHALL have port out_valid  output  1  out_data holds a beat.
REQ-014 SHALL have port out_ready  input  1  downstream accepts beat.

Function
REQ-015 Input transfer on channel c SHALL occur in a cycle where in_valid[c] and in_ready[c] are both 1; output transfer where out_valid and out_ready are both 1.
REQ-016 At most one in_ready bit SHALL be 1 per cycle; in_ready[c] = grant[c] AND (NOT out_valid OR out_ready).
REQ-017 Accepted beat SHALL appear on out_data/out_chan with out_valid=1 on the next rising edge (latency 1); back-to-back throughput 1 beat/cycle when out_ready stays 1.
REQ-018 out_data, out_chan, out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 Output transfer with no new input transfer SHALL clear out_valid next cycle; simultaneous output and input transfer SHALL keep out_valid=1 and load the new beat.
REQ-020 Select mode: grant[sel]=in_valid[sel]; all other grants 0; sel >= CHANNELS SHALL grant nothing.
REQ-021 sel changes SHALL take effect the same cycle and SHALL NOT disturb a held output beat.
REQ-022 Round-robin mode: grant the first valid channel searching from rr_ptr+1 upward, wrapping CHANNELS-1 -> 0; sel ignored.
REQ-023 rr_ptr SHALL update to the granted channel only on an input transfer; stall cycles SHALL leave it unchanged.
REQ-024 No in_valid set SHALL produce no grant, all in_ready=0, and unchanged rr_ptr.
REQ-025 Mode change SHALL take effect the next arbitration cycle without clearing rr_ptr or the output register.

Reset
REQ-026 reset SHALL asynchronously force out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1 (channel 0 wins first).
REQ-027 A beat held at reset assertion SHALL be discarded; in_ready SHALL be all 0 while reset is high.
REQ-028 First transfer after deassertion SHALL be possible on the first rising edge with reset low.

Configuration
REQ-029 Macro MUX_STREAM_RR_EN defined: round-robin logic and rr_ptr SHALL be built and mode honoured.
REQ-030 Macro undefined: mode SHALL be ignored, select mode always, no rr_ptr storage.

Structure
REQ-031 Shared package mux_pkg SHALL hold MODE_SEL=0/MODE_RR=1 constants and the clog2 function.
REQ-032 Round-robin grant logic SHALL be sub-module mux_rr_arb (inputs req, ptr; output one-hot grant), instantiated only under MUX_STREAM_RR_EN.

Verification
REQ-033 Select: mode=0, sel=2, in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=BEEF, out_chan=2, out_valid=1.
REQ-034 Backpressure: held beat 16'h1234, out_ready=0 for 5 cycles, ch1 valid -> in_ready=0, out_data stays 1234; out_ready=1 -> ch1 beat loads the following cycle.
REQ-035 Round-robin: mode=1, in_valid=4'b1111, out_ready=1 from reset -> out_chan 0,1,2,3,0 on consecutive cycles.
REQ-036 Round-robin skip: in_valid=4'b1001 after ch0 grant -> next grant ch3, then ch0.
REQ-037 Out-of-range: CHANNELS=3, sel=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
REQ-038 Reset mid-operation: out_valid=1, assert reset between edges -> out_valid=0 immediately; first post-reset RR grant is ch0.
